// File: rtl/axi_line_writer_pkg.sv
// Shared encodings for the cache write-side AXI back end.
package axi_line_writer_pkg;

    localparam logic [2:0] WR_TYPE_BYTE = 3'b000;
    localparam logic [2:0] WR_TYPE_HALF = 3'b001;
    localparam logic [2:0] WR_TYPE_WORD = 3'b010;
    localparam logic [2:0] WR_TYPE_LINE = 3'b100;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [7:0] AXI_LEN_LINE   = 8'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } state_e;

endpackage

// File: rtl/axi_line_writer.sv
// One-entry write buffer that turns a cache line eviction or uncached store
// into a single AXI write burst, plus a line-address hazard check for reads.
module axi_line_writer
    import axi_line_writer_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         wr_req,
    input  logic [2:0]   wr_type,
    input  logic [31:0]  wr_addr,
    input  logic [3:0]   wr_wstrb,
    input  logic [127:0] wr_data,
    output logic         wr_rdy,
    input  logic [31:0]  chk_addr,
    output logic         chk_hit,
    output logic [3:0]   awid,
    output logic [31:0]  awaddr,
    output logic [7:0]   awlen,
    output logic [2:0]   awsize,
    output logic [1:0]   awburst,
    output logic [1:0]   awlock,
    output logic [3:0]   awcache,
    output logic [2:0]   awprot,
    output logic         awvalid,
    input  logic         awready,
    output logic [3:0]   wid,
    output logic [31:0]  wdata,
    output logic [3:0]   wstrb,
    output logic         wlast,
    output logic         wvalid,
    input  logic         wready,
    input  logic [3:0]   bid,
    input  logic [1:0]   bresp,
    input  logic         bvalid,
    output logic         bready,
    output logic         bresp_err
);

    state_e         state_q, state_d;
    logic           valid_q, valid_d;
    logic [2:0]     type_q, type_d;
    logic [31:0]    addr_q, addr_d;
    logic [3:0]     wstrb_q, wstrb_d;
    logic [127:0]   data_q, data_d;
    logic [1:0]     beat_q, beat_d;
    logic           bresp_err_q, bresp_err_d;
    logic           is_line;

    // Response ID carries no information for a single-outstanding master.
    logic unused_bid;
    assign unused_bid = ^bid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            valid_q     <= 1'b0;
            type_q      <= 3'd0;
            addr_q      <= 32'd0;
            wstrb_q     <= 4'd0;
            data_q      <= 128'd0;
            beat_q      <= 2'd0;
            bresp_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            type_q      <= type_d;
            addr_q      <= addr_d;
            wstrb_q     <= wstrb_d;
            data_q      <= data_d;
            beat_q      <= beat_d;
            bresp_err_q <= bresp_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        type_d      = type_q;
        addr_d      = addr_q;
        wstrb_d     = wstrb_q;
        data_d      = data_q;
        beat_d      = beat_q;
        bresp_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_req) begin
                    valid_d = 1'b1;
                    type_d  = wr_type;
                    addr_d  = wr_addr;
                    wstrb_d = wr_wstrb;
                    data_d  = wr_data;
                    beat_d  = 2'd0;
                    state_d = ST_AW;
                end
            end
            ST_AW: begin
                if (awready) begin
                    state_d = ST_W;
                end
            end
            ST_W: begin
                if (wready) begin
                    if (wlast) begin
                        state_d = ST_B;
                    end else begin
                        beat_d = beat_q + 2'd1;
                    end
                end
            end
            ST_B: begin
                if (bvalid) begin
                    state_d     = ST_IDLE;
                    valid_d     = 1'b0;
                    bresp_err_d = (bresp != AXI_RESP_OKAY);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign is_line = (type_q == WR_TYPE_LINE);

    assign wr_rdy    = (state_q == ST_IDLE);
    assign chk_hit   = valid_q && (addr_q[31:4] == chk_addr[31:4]);
    assign bresp_err = bresp_err_q;

    // All channel payload is taken from registers so it cannot glitch with ready.
    assign awid    = AXI_ID;
    assign awaddr  = is_line ? {addr_q[31:4], 4'h0} : addr_q;
    assign awlen   = is_line ? AXI_LEN_LINE : 8'd0;
    assign awsize  = is_line ? AXI_SIZE_4B : {1'b0, type_q[1:0]};
    assign awburst = AXI_BURST_INCR;
    assign awlock  = 2'b00;
    assign awcache = 4'h0;
    assign awprot  = 3'h0;
    assign awvalid = (state_q == ST_AW);

    assign wid    = AXI_ID;
    assign wdata  = data_q[{beat_q, 5'd0} +: 32];
    assign wstrb  = is_line ? 4'hf : wstrb_q;
    assign wlast  = (state_q == ST_W) && ({6'd0, beat_q} == awlen);
    assign wvalid = (state_q == ST_W);

    assign bready = (state_q == ST_B);

endmodule
